// File: rtl/controlador_entrada_if.sv
// Request/ready handshake between the processor input path and controlador_entrada.
// The processor is the master (drives the request); the input controller is the slave.
interface controlador_entrada_if #(
  parameter int LARGURA_DADO = 32
);
  logic                    pedidoEntrada;
  logic [LARGURA_DADO-1:0] dadoEntrada;
  logic                    entradaPronta;

  modport master (
    output pedidoEntrada,
    input  dadoEntrada,
    input  entradaPronta
  );

  modport slave (
    input  pedidoEntrada,
    output dadoEntrada,
    output entradaPronta
  );
endinterface

// File: rtl/controlador_entrada.sv
// User input responder: synchronises/debounces the confirm button and switch bank, then
// answers the processor's request. Define ENTRADA_SINAL_EN to sign-extend the switches.
module controlador_entrada #(
  parameter int DEBOUNCE_CICLOS = 250000,
  parameter int LARGURA_ENTRADA = 5,
  parameter int LARGURA_DADO    = 32
) (
  input  logic                       clkFPGA,
  input  logic                       Reset,
  input  logic [LARGURA_ENTRADA-1:0] entradaFPGA,
  input  logic                       botao,
  output logic                       aguardando,
  controlador_entrada_if.slave       barramento
);

  localparam int LARGURA_CNT = $clog2(DEBOUNCE_CICLOS);
  localparam logic [LARGURA_CNT-1:0] CNT_LIMITE = LARGURA_CNT'(DEBOUNCE_CICLOS - 1);

  typedef enum logic [1:0] {
    OCIOSO,
    AGUARDA_BOTAO,
    PRONTO,
    AGUARDA_FIM
  } estado_t;

  estado_t                    estado;
  estado_t                    proximo;
  logic                       captura;

  logic                       botao_meta;
  logic                       botao_sync;
  logic [LARGURA_ENTRADA-1:0] chaves_meta;
  logic [LARGURA_ENTRADA-1:0] chaves_sync;

  logic [LARGURA_CNT-1:0]     cnt;
  logic                       botao_estavel;
  logic                       botao_estavel_ant;
  logic                       pressao;

  logic [LARGURA_DADO-1:0]    chaves_ext;
  logic [LARGURA_DADO-1:0]    dado_reg;
  logic                       pronta_reg;

  always_ff @(posedge clkFPGA) begin
    if (Reset) begin
      botao_meta  <= 1'b0;
      botao_sync  <= 1'b0;
      chaves_meta <= '0;
      chaves_sync <= '0;
    end else begin
      botao_meta  <= botao;
      botao_sync  <= botao_meta;
      chaves_meta <= entradaFPGA;
      chaves_sync <= chaves_meta;
    end
  end

  // A new button level is accepted only after it has held for DEBOUNCE_CICLOS cycles.
  always_ff @(posedge clkFPGA) begin
    if (Reset) begin
      cnt               <= '0;
      botao_estavel     <= 1'b0;
      botao_estavel_ant <= 1'b0;
    end else begin
      botao_estavel_ant <= botao_estavel;
      if (botao_sync == botao_estavel) begin
        cnt <= '0;
      end else if (cnt == CNT_LIMITE) begin
        botao_estavel <= botao_sync;
        cnt           <= '0;
      end else if (cnt != '1) begin
        cnt <= cnt + LARGURA_CNT'(1);
      end
    end
  end

  assign pressao = botao_estavel & ~botao_estavel_ant;

  always_comb begin
`ifdef ENTRADA_SINAL_EN
    chaves_ext = {{(LARGURA_DADO-LARGURA_ENTRADA){chaves_sync[LARGURA_ENTRADA-1]}}, chaves_sync};
`else
    chaves_ext = {{(LARGURA_DADO-LARGURA_ENTRADA){1'b0}}, chaves_sync};
`endif
  end

  always_ff @(posedge clkFPGA) begin
    if (Reset) begin
      estado     <= OCIOSO;
      dado_reg   <= '0;
      pronta_reg <= 1'b0;
      aguardando <= 1'b0;
    end else begin
      estado     <= proximo;
      pronta_reg <= (proximo == PRONTO);
      aguardando <= (proximo == AGUARDA_BOTAO);
      if (captura) begin
        dado_reg <= chaves_ext;
      end
    end
  end

  // A withdrawn request beats a simultaneous press; AGUARDA_FIM waits for release so a
  // single held press cannot answer two requests.
  always_comb begin
    proximo = estado;
    captura = 1'b0;
    unique case (estado)
      OCIOSO: begin
        if (barramento.pedidoEntrada) begin
          proximo = AGUARDA_BOTAO;
        end
      end
      AGUARDA_BOTAO: begin
        if (!barramento.pedidoEntrada) begin
          proximo = OCIOSO;
        end else if (pressao) begin
          captura = 1'b1;
          proximo = PRONTO;
        end
      end
      PRONTO: begin
        if (!barramento.pedidoEntrada) begin
          proximo = AGUARDA_FIM;
        end
      end
      AGUARDA_FIM: begin
        if (!botao_estavel) begin
          proximo = OCIOSO;
        end
      end
      default: proximo = OCIOSO;
    endcase
  end

  assign barramento.dadoEntrada   = dado_reg;
  assign barramento.entradaPronta = pronta_reg;

endmodule

// File: tb/tb_controlador_entrada.sv
// Directed bench for controlador_entrada with DEBOUNCE_CICLOS=4: table-driven transfers
// plus hand-written sequences for bounce, held button, idle press, withdrawal and reset.
module tb_controlador_entrada;

  logic       clk;
  logic       rst;
  logic [4:0] chaves;
  logic       botao;
  logic       aguardando;

  controlador_entrada_if #(.LARGURA_DADO(32)) bus ();

  controlador_entrada #(
    .DEBOUNCE_CICLOS(4),
    .LARGURA_ENTRADA(5),
    .LARGURA_DADO(32)
  ) dut (
    .clkFPGA    (clk),
    .Reset      (rst),
    .entradaFPGA(chaves),
    .botao      (botao),
    .aguardando (aguardando),
    .barramento (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  chaves;
    logic [31:0] esperado;
  } vetor_t;

  vetor_t vetores[5];
  int     checks = 0;
  int     errors = 0;

  // Advance n rising edges and settle 1 time unit past the last one.
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_output(input string nome, input logic [31:0] atual, input logic [31:0] esperado);
    checks++;
    if (atual !== esperado) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", nome, atual, esperado);
    end
  endtask

  task automatic apply_stimulus(input logic [4:0] sw, input logic ped, input logic bt);
    chaves            = sw;
    bus.pedidoEntrada = ped;
    botao             = bt;
  endtask

  // Full transfer from idle with a clean press, then release back to idle.
  task automatic do_transfer(input int idx, input logic [4:0] sw, input logic [31:0] esperado);
    apply_stimulus(sw, 1'b1, 1'b1);
    step(6);
    check_output($sformatf("v%0d pronta_before", idx), {31'd0, bus.entradaPronta}, 32'd0);
    check_output($sformatf("v%0d aguardando_wait", idx), {31'd0, aguardando}, 32'd1);
    step(1);
    check_output($sformatf("v%0d pronta", idx), {31'd0, bus.entradaPronta}, 32'd1);
    check_output($sformatf("v%0d dado", idx), bus.dadoEntrada, esperado);
    check_output($sformatf("v%0d aguardando_off", idx), {31'd0, aguardando}, 32'd0);
    bus.pedidoEntrada = 1'b0;
    step(1);
    check_output($sformatf("v%0d pronta_drop", idx), {31'd0, bus.entradaPronta}, 32'd0);
    botao = 1'b0;
    step(8);
    check_output($sformatf("v%0d idle_aguardando", idx), {31'd0, aguardando}, 32'd0);
  endtask

  initial begin
    logic [31:0] dado_ant;

    vetores[0] = '{5'd19, 32'h0000_0013};
    vetores[1] = '{5'd0,  32'h0000_0000};
    vetores[2] = '{5'd1,  32'h0000_0001};
`ifdef ENTRADA_SINAL_EN
    vetores[3] = '{5'b10110, 32'hFFFF_FFF6};
    vetores[4] = '{5'd31,    32'hFFFF_FFFF};
`else
    vetores[3] = '{5'b10110, 32'h0000_0016};
    vetores[4] = '{5'd31,    32'h0000_001F};
`endif

    rst = 1'b1;
    apply_stimulus(5'd0, 1'b0, 1'b0);
    step(2);
    check_output("reset dado", bus.dadoEntrada, 32'd0);
    check_output("reset pronta", {31'd0, bus.entradaPronta}, 32'd0);
    check_output("reset aguardando", {31'd0, aguardando}, 32'd0);
    rst = 1'b0;
    step(2);

    for (int i = 0; i < 5; i++) begin
      do_transfer(i, vetores[i].chaves, vetores[i].esperado);
    end

    // Bounce rejection.
    dado_ant = bus.dadoEntrada;
    apply_stimulus(5'd12, 1'b1, 1'b0);
    step(2);
    check_output("bounce aguardando_start", {31'd0, aguardando}, 32'd1);
    for (int i = 0; i < 8; i++) begin
      botao = (i % 2 == 0);
      step(1);
    end
    botao = 1'b0;
    step(10);
    check_output("bounce pronta", {31'd0, bus.entradaPronta}, 32'd0);
    check_output("bounce aguardando", {31'd0, aguardando}, 32'd1);
    check_output("bounce dado", bus.dadoEntrada, dado_ant);
    bus.pedidoEntrada = 1'b0;
    step(2);
    check_output("withdraw aguardando", {31'd0, aguardando}, 32'd0);

    // Held button across two requests.
    apply_stimulus(5'd19, 1'b1, 1'b1);
    step(7);
    check_output("held first pronta", {31'd0, bus.entradaPronta}, 32'd1);
    check_output("held first dado", bus.dadoEntrada, 32'h13);
    bus.pedidoEntrada = 1'b0;
    step(1);
    check_output("held pronta_drop", {31'd0, bus.entradaPronta}, 32'd0);
    apply_stimulus(5'd7, 1'b1, 1'b1);
    step(10);
    check_output("held no_second pronta", {31'd0, bus.entradaPronta}, 32'd0);
    check_output("held no_second aguardando", {31'd0, aguardando}, 32'd0);
    check_output("held no_second dado", bus.dadoEntrada, 32'h13);
    botao = 1'b0;
    step(4);
    check_output("held release_early aguardando", {31'd0, aguardando}, 32'd0);
    step(4);
    check_output("held release aguardando", {31'd0, aguardando}, 32'd1);
    botao = 1'b1;
    step(6);
    check_output("held second pronta_before", {31'd0, bus.entradaPronta}, 32'd0);
    step(1);
    check_output("held second pronta", {31'd0, bus.entradaPronta}, 32'd1);
    check_output("held second dado", bus.dadoEntrada, 32'h7);
    apply_stimulus(5'd7, 1'b0, 1'b0);
    step(10);

    // Press and release while idle must be discarded.
    apply_stimulus(5'd9, 1'b0, 1'b1);
    step(8);
    botao = 1'b0;
    step(8);
    bus.pedidoEntrada = 1'b1;
    step(3);
    check_output("idle aguardando", {31'd0, aguardando}, 32'd1);
    check_output("idle pronta", {31'd0, bus.entradaPronta}, 32'd0);
    check_output("idle dado", bus.dadoEntrada, 32'h7);
    step(5);
    check_output("idle still_waiting", {31'd0, aguardando}, 32'd1);

    // Reset while in PRONTO.
    apply_stimulus(5'd31, 1'b1, 1'b1);
    step(7);
    check_output("pre_reset pronta", {31'd0, bus.entradaPronta}, 32'd1);
    check_output("pre_reset dado", bus.dadoEntrada, vetores[4].esperado);
    rst = 1'b1;
    apply_stimulus(5'd31, 1'b0, 1'b0);
    step(1);
    check_output("midreset pronta", {31'd0, bus.entradaPronta}, 32'd0);
    check_output("midreset dado", bus.dadoEntrada, 32'd0);
    check_output("midreset aguardando", {31'd0, aguardando}, 32'd0);
    rst = 1'b0;
    step(10);

    // Withdrawal in the same cycle as the press event wins.
    apply_stimulus(5'd19, 1'b1, 1'b1);
    step(6);
    bus.pedidoEntrada = 1'b0;
    step(1);
    check_output("race pronta", {31'd0, bus.entradaPronta}, 32'd0);
    check_output("race aguardando", {31'd0, aguardando}, 32'd0);
    check_output("race dado", bus.dadoEntrada, 32'd0);
    botao = 1'b0;
    step(10);
    bus.pedidoEntrada = 1'b1;
    step(2);
    check_output("race recover aguardando", {31'd0, aguardando}, 32'd1);
    bus.pedidoEntrada = 1'b0;
    step(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
